// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares the single instruction-memory read port between the fetch unit
// and a debug/loader read requester. In-flight requests are tracked in an
// in-order ownership FIFO, so each returned word is routed back to whoever
// issued it. IFU responses made stale by a redirect (ifu_flush) are dropped.

module imem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  // fetch unit request / redirect / response
  input  logic              ifu_req_valid,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  input  logic [TAG_W-1:0]  ifu_req_tag,
  output logic              ifu_req_ready,
  input  logic              ifu_flush,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  output logic [TAG_W-1:0]  ifu_rsp_tag,

  // debug / loader request / response
  input  logic              dbg_req_valid,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [TAG_W-1:0]  dbg_req_tag,
  output logic              dbg_req_ready,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_data,
  output logic [TAG_W-1:0]  dbg_rsp_tag,

  // instruction memory port
  output logic [ADDR_W-1:0] instr_mem_addr,
  output logic              instr_mem_addr_valid,
  output logic [TAG_W-1:0]  instr_mem_tag_out,
  input  logic [DATA_W-1:0] instr_mem_rdata,
  input  logic              instr_mem_rdata_valid,
  input  logic [TAG_W-1:0]  instr_mem_tag_in,

  // status
  output logic [$clog2(MAX_OUTST):0] outst_cnt,
  output logic              rsp_err
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  // owner encoding used both in the FIFO and in last_grant
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // ownership FIFO: one owner bit and one kill bit per slot
  logic [MAX_OUTST-1:0] own_q;
  logic [MAX_OUTST-1:0] kill_q;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     cnt_q;

  logic last_grant;
  logic rsp_err_q;

  logic full;
  logic empty;
  logic ifu_elig;
  logic dbg_elig;
  logic grant_ifu;
  logic grant_dbg;
  logic grant;
  logic pop;
  logic spurious;
  logic head_own;
  logic head_kill;

  // Occupancy. A response in the same cycle does not free a slot until the
  // counter actually drops, so "full" only looks at the registered count.
  assign full  = (cnt_q == CNT_W'(MAX_OUTST));
  assign empty = (cnt_q == '0);

  // Eligibility. A redirecting IFU must not issue the fetch it is presenting
  // in the same cycle, since that fetch belongs to the old PC stream.
  // Gating with rst_n keeps the readies low while reset is held.
  assign ifu_elig = rst_n & ifu_req_valid & ~ifu_flush & ~full;
  assign dbg_elig = rst_n & dbg_req_valid & ~full;

  // Round-robin: with both eligible, whoever did not win last time wins.
  assign grant_ifu = ifu_elig & (~dbg_elig | (last_grant == OWN_DBG));
  assign grant_dbg = dbg_elig & ~grant_ifu;
  assign grant     = grant_ifu | grant_dbg;

  assign ifu_req_ready = grant_ifu;
  assign dbg_req_ready = grant_dbg;

  // Request mux toward memory; when nobody is granted the IFU side is shown
  // but addr_valid stays low.
  assign instr_mem_addr_valid = grant;
  assign instr_mem_addr       = grant_dbg ? dbg_req_addr : ifu_req_addr;
  assign instr_mem_tag_out    = grant_dbg ? dbg_req_tag  : ifu_req_tag;

  // Response routing from the FIFO head. A response with nothing
  // outstanding has no owner; it is flagged and otherwise ignored.
  assign pop       = instr_mem_rdata_valid & ~empty;
  assign spurious  = instr_mem_rdata_valid &  empty;
  assign head_own  = own_q[rd_ptr];
  assign head_kill = kill_q[rd_ptr];

  // The flush term covers an IFU entry popped in the very cycle of the
  // redirect: its kill bit would only be written at the clock edge.
  assign ifu_rsp_valid = pop & (head_own == OWN_IFU) & ~head_kill & ~ifu_flush;
  assign dbg_rsp_valid = pop & (head_own == OWN_DBG);

  assign ifu_rsp_data = instr_mem_rdata;
  assign ifu_rsp_tag  = instr_mem_tag_in;
  assign dbg_rsp_data = instr_mem_rdata;
  assign dbg_rsp_tag  = instr_mem_tag_in;

  assign outst_cnt = cnt_q;
  assign rsp_err   = rsp_err_q;

  // FIFO contents: kill marking on redirect, then the new entry on a grant
  // (written last so a freshly pushed slot always starts with kill=0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q  <= '0;
      kill_q <= '0;
    end else begin
      if (ifu_flush) begin
        for (int i = 0; i < MAX_OUTST; i++) begin
          if (own_q[i] == OWN_IFU) begin
            kill_q[i] <= 1'b1;
          end
        end
      end
      if (grant) begin
        own_q[wr_ptr]  <= grant_dbg;
        kill_q[wr_ptr] <= 1'b0;
      end
    end
  end

  // FIFO pointers and the in-flight counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (grant) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({grant, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Round-robin memory; starts at dbg so the IFU wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= OWN_DBG;
    end else if (grant) begin
      last_grant <= grant_dbg;
    end
  end

  // Sticky error for responses that arrive with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (spurious) begin
      rsp_err_q <= 1'b1;
    end
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single instruction-memory read port between the fetch unit (IFU) and a debug/loader read requester, and routes returned words back to their owner. It sits between the IFU and the instruction memory and passes the memory interface through unchanged in width. It tracks in-flight requests in an in-order ownership FIFO. It also discards IFU responses made stale by a redirect (PC load).

## Interface
Parameters:
- ADDR_W, INSTR_MEM_ADDR_WIDTH, memory address width
- DATA_W, INSTR_MEM_WIDTH, memory read-data width
- TAG_W, XLEN, request/response tag width (must be ≤ INSTR_MEM_TAG_WIDTH)
- MAX_OUTST, 4, maximum in-flight requests (power of two, ≥2)

Ports:
- clk  in  1  clock; one clock domain, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid / ifu_req_addr / ifu_req_tag  in  1 / ADDR_W / TAG_W  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_flush  in  1  IFU redirect (pc_load); kills in-flight IFU requests
- ifu_rsp_valid / ifu_rsp_data / ifu_rsp_tag  out  1 / DATA_W / TAG_W  IFU response
- dbg_req_valid / dbg_req_addr / dbg_req_tag  in  1 / ADDR_W / TAG_W  debug read request
- dbg_req_ready  out  1  debug request accepted this cycle
- dbg_rsp_valid / dbg_rsp_data / dbg_rsp_tag  out  1 / DATA_W / TAG_W  debug response
- instr_mem_addr / instr_mem_addr_valid / instr_mem_tag_out  out  ADDR_W / 1 / TAG_W  memory request
- instr_mem_rdata / instr_mem_rdata_valid / instr_mem_tag_in  in  DATA_W / 1 / TAG_W  memory response
- outst_cnt  out  $clog2(MAX_OUTST)+1  in-flight request count
- rsp_err  out  1  sticky: response arrived with nothing outstanding

## Operation
- The memory accepts every valid request and returns responses strictly in issue order. Latency is ≥1 cycle and arbitrary.
- Requests are eligible only when outst_cnt < MAX_OUTST. At most one request is granted per cycle.
- Arbitration is round-robin on a 1-bit last_grant register.
  - When both requesters are valid, the one not granted last wins.
  - A lone valid requester always wins.
  - last_grant updates only on a grant.
- The IFU request is not eligible in a cycle with ifu_flush=1. That request is never granted and never issued.
- Grant path:
  - The winner's addr and tag are muxed onto instr_mem_addr and instr_mem_tag_out.
  - instr_mem_addr_valid = grant.
  - Matching *_req_ready = 1.
  - An entry {owner, kill=0} is pushed into the ownership FIFO (depth MAX_OUTST).
- Response path (instr_mem_rdata_valid=1):
  - The FIFO head is popped.
  - If owner=dbg: dbg_rsp_valid=1.
  - If owner=ifu and kill=0: ifu_rsp_valid=1.
  - If owner=ifu and kill=1: the response is dropped; no valid is raised.
  - Data and tag pass from memory unchanged.
- ifu_flush=1: every FIFO entry with owner=ifu gets kill=1 that cycle. This includes the entry popped that same cycle, whose response is dropped.
- Debug entries are never killed.
- outst_cnt:
  - +1 on push, −1 on pop, unchanged when both happen in the same cycle.
  - Width rule: never exceeds MAX_OUTST.
- Response with outst_cnt=0: ignored (no pop, no rsp valid); rsp_err set until reset.
- Reset values:
  - outst_cnt=0, FIFO empty, last_grant=dbg (so IFU wins the first contention).
  - rsp_err=0; all *_valid and *_ready outputs 0.
  - Data/tag outputs are don't-care.
- Reset mid-operation: all in-flight ownership is lost. Responses arriving after reset hit the empty FIFO and set rsp_err; the system must reset memory together with this block.

## Timing
- Request path is combinational: grant, ready and instr_mem_* are valid in the same cycle as *_req_valid. Zero added latency.
- Response path is combinational from instr_mem_rdata_valid plus the FIFO head: zero added latency.
- FIFO push/pop, kill marking, last_grant and outst_cnt update on the rising clk edge.
- Full condition (outst_cnt=MAX_OUTST): both readies are 0. A same-cycle response does not free a slot until the next cycle; there is no bypass.
- Simultaneous push, pop and flush in one cycle:
  - The popped IFU entry is dropped.
  - A new dbg push is unaffected.
  - No IFU push can occur that cycle.

## Test plan
- Reset, then IFU-only requests at addr 0x0,0x4,0x8 with memory latency 2 → three ifu_rsp_valid pulses in order with matching tags; dbg_rsp_valid never asserts; outst_cnt peaks at 2.
- Both valid for 4 consecutive cycles → grants ifu, dbg, ifu, dbg; each response routes to its issuer.
- MAX_OUTST=4, memory stalls responses → after 4 grants both readies=0. One response → readies return the next cycle, not the same cycle.
- Two IFU and one dbg request in flight, ifu_flush pulse → both IFU responses dropped (no ifu_rsp_valid); dbg response delivered; outst_cnt returns to 0.
- Flush in the same cycle as an IFU response → that response dropped; a dbg request granted that cycle completes normally.
- instr_mem_rdata_valid with outst_cnt=0 → no rsp valids; rsp_err=1 and stays 1 until rst_n low.
